// File: rtl/control_unit_pkg.sv
// Shared control-unit encodings: next-state source selects, condition selects
// and the fixed microstore entry points.
package control_unit_pkg;

  typedef enum logic [1:0] {
    SEL_ENCODER = 2'b00,
    SEL_FETCH   = 2'b01,
    SEL_BRANCH  = 2'b10,
    SEL_WAIT    = 2'b11
  } sel_e;

  typedef enum logic [2:0] {
    COND_FALSE = 3'b000,
    COND_TRUE  = 3'b001,
    COND_MOC   = 3'b010,
    COND_CC    = 3'b011,
    COND_Z     = 3'b100,
    COND_NFLAG = 3'b101,
    COND_C     = 3'b110,
    COND_V     = 3'b111
  } cond_e;

  localparam int FETCH_STATE = 1;
  localparam int RESET_STATE = 0;

endpackage

// File: rtl/microsequencer_if.sv
// Control-register to microsequencer bundle: microinstruction fields and
// status inputs in one direction, the sequencer state and fault back.
interface microsequencer_if #(
  parameter int STATE_W = 10
);
  logic [STATE_W-1:0] cr;
  logic [2:0]         N;
  logic               inv;
  logic [1:0]         select;
  logic [STATE_W-1:0] encoder_state;
  logic               moc;
  logic               cond;
  logic [3:0]         flags;
  logic [STATE_W-1:0] current_state;
  logic               fault;

  modport master (
    output cr, N, inv, select, encoder_state, moc, cond, flags,
    input  current_state, fault
  );

  modport slave (
    input  cr, N, inv, select, encoder_state, moc, cond, flags,
    output current_state, fault
  );
endinterface

// File: rtl/microseq_cond_sel.sv
// 8:1 branch-condition mux with optional inversion; purely combinational.
module microseq_cond_sel
  import control_unit_pkg::*;
(
  input  logic [2:0] N,
  input  logic       inv,
  input  logic       moc,
  input  logic       cond,
  input  logic [3:0] flags,
  output logic       sts
);

  logic raw;

  // flags is packed {Z, N, C, V}
  always_comb begin
    raw = 1'b0;
    case (N)
      COND_FALSE: raw = 1'b0;
      COND_TRUE:  raw = 1'b1;
      COND_MOC:   raw = moc;
      COND_CC:    raw = cond;
      COND_Z:     raw = flags[3];
      COND_NFLAG: raw = flags[2];
      COND_C:     raw = flags[1];
      COND_V:     raw = flags[0];
      default:    raw = 1'b0;
    endcase
  end

  assign sts = raw ^ inv;

endmodule

// File: rtl/microsequencer.sv
// Microprogram sequencer: registered control-state address with encoder,
// fetch, conditional branch and conditional wait sources plus a stall watchdog.
module microsequencer
  import control_unit_pkg::*;
#(
  parameter int                 STATE_W     = 10,
  parameter int                 STALL_LIMIT = 255,
  parameter logic [STATE_W-1:0] FAULT_STATE = 10'd1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] cr,
  input  logic [2:0]         N,
  input  logic               inv,
  input  logic [1:0]         select,
  input  logic [STATE_W-1:0] encoder_state,
  input  logic               moc,
  input  logic               cond,
  input  logic [3:0]         flags,
  output logic [STATE_W-1:0] current_state,
  output logic               fault
);

  localparam int CNT_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STALL_LIMIT);

  logic [STATE_W-1:0] state_reg, state_next, state_inc;
  logic [CNT_W-1:0]   stall_cnt_reg, stall_cnt_next;
  logic               fault_reg, fault_next;
  logic               sts, hold, timeout;

  microseq_cond_sel u_cond_sel (
    .N     (N),
    .inv   (inv),
    .moc   (moc),
    .cond  (cond),
    .flags (flags),
    .sts   (sts)
  );

  assign state_inc = state_reg + STATE_W'(1);
  assign hold      = (select == SEL_WAIT) && !sts;
  assign timeout   = hold && (stall_cnt_reg == CNT_LIMIT);

  always_comb begin
    state_next = state_reg;
    case (select)
      SEL_ENCODER: state_next = encoder_state;
      SEL_FETCH:   state_next = STATE_W'(FETCH_STATE);
      SEL_BRANCH:  state_next = sts ? cr : state_inc;
      SEL_WAIT:    state_next = sts ? state_inc : state_reg;
      default:     state_next = state_reg;
    endcase
    // A stalled wait that has exhausted its budget overrides every source.
    if (timeout) begin
      state_next = FAULT_STATE;
    end
  end

  always_comb begin
    stall_cnt_next = '0;
    if (hold && !timeout) begin
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end
    fault_next = fault_reg | timeout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= STATE_W'(RESET_STATE);
      stall_cnt_reg <= '0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      stall_cnt_reg <= stall_cnt_next;
      fault_reg     <= fault_next;
    end
  end

  assign current_state = state_reg;
  assign fault         = fault_reg;

endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 SHALL have parameter STATE_W, default 10, giving the control-state address width.
REQ-002 SHALL have parameter STALL_LIMIT, default 255, giving the maximum number of consecutive hold cycles before a fault.
REQ-003 SHALL have parameter FAULT_STATE, default 10'd1023, giving the state entered on stall timeout.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port cr, input, STATE_W bits: microinstruction branch target, taken from the control register.
REQ-007 SHALL have port N, input, 3 bits: condition select, taken from the control register.
REQ-008 SHALL have port inv, input, 1 bit: condition invert, taken from the control register.
REQ-009 SHALL have port select, input, 2 bits: next-state source select, taken from the control register.
REQ-010 SHALL have port encoder_state, input, STATE_W bits: instruction-decode entry state from the IR encoder.
REQ-011 SHALL have port moc, input, 1 bit: memory operation complete.
REQ-012 SHALL have port cond, input, 1 bit: condition-code test result.
REQ-013 SHALL have port flags, input, 4 bits: {Z,N,C,V} status flags.
REQ-014 SHALL have port current_state, output, STATE_W bits: registered state; addresses the microstore and feeds the control register current_state input.
REQ-015 SHALL have port fault, output, 1 bit: sticky stall-timeout indicator.

Function
REQ-016 SHALL compute the raw condition from N: 000 false; 001 true; 010 moc; 011 cond; 100 Z; 101 N-flag; 110 C; 111 V.
REQ-017 SHALL compute sts = raw condition XOR inv.
REQ-018 SHALL choose next state by select: 00 encoder_state; 01 FETCH_STATE (1); 10 sts ? cr : current_state+1; 11 sts ? current_state+1 : current_state (hold).
REQ-019 SHALL compute the incrementer modulo 2^STATE_W, so state 1023 increments to 0.
REQ-020 SHALL register next state into current_state on every rising clk edge; latency from inputs to current_state is exactly one cycle.
REQ-021 SHALL treat all inputs as stable registered outputs of the control register; next-state logic is purely combinational from inputs and current_state.
REQ-022 SHALL increment an internal stall counter on each cycle in which select=11 and sts=0; any other cycle clears it to 0.
REQ-023 SHALL, when a hold cycle occurs with the counter equal to STALL_LIMIT, load FAULT_STATE instead of holding, set fault, and clear the counter.
REQ-024 SHALL keep fault at 1 until reset; while fault=1, sequencing continues normally from FAULT_STATE.
REQ-025 SHALL give the fault path priority over every select case; a select change in the same cycle simply clears the counter.

Reset
REQ-026 SHALL, when reset=1 at a rising edge, set current_state=0, stall counter=0 and fault=0, regardless of select or any pending hold or timeout.
REQ-027 SHALL apply reset in the middle of a stall by discarding the accumulated count.
REQ-028 SHALL, on the first edge after reset deasserts, evaluate next state normally from state 0.

Structure
REQ-029 SHALL define in shared package control_unit_pkg: the SEL_ENCODER/SEL_FETCH/SEL_BRANCH/SEL_WAIT encodings, the N condition encodings, FETCH_STATE=1 and RESET_STATE=0.
REQ-030 SHALL place the 8:1 condition mux plus invert in sub-module microseq_cond_sel (inputs N, inv, moc, cond, flags; output sts).
REQ-031 SHALL keep the state register, incrementer, next-state mux and stall counter in the top module.

Verification
REQ-032 SHALL verify reset: reset=1 for 2 cycles with select=00 and encoder_state=37 -> current_state=0, fault=0; the first cycle after release -> 37.
REQ-033 SHALL verify branch: select=10, N=100, inv=0, Z=1, cr=200 from state 5 -> 200; same with Z=0 -> 6; inv=1 with Z=1 -> 6.
REQ-034 SHALL verify wait: select=11, N=010, moc=0 for 3 cycles at state 12 -> holds 12; moc=1 -> 13 on the next edge.
REQ-035 SHALL verify wrap: state 1023, select=10, N=000 -> 0.
REQ-036 SHALL verify timeout: STALL_LIMIT=4, hold with moc=0 -> state stays for 5 cycles, then 1023 with fault=1; fault stays 1 after moc=1 until reset.
REQ-037 SHALL verify fetch: select=01 from any state -> 1 in one cycle.
